// File: rtl/t_counter_pkg.sv
// Shared opcodes, FSM state type and command helpers for the T-counter sequencer.
package t_counter_pkg;

    localparam logic [1:0] OP_STOP     = 2'b00;
    localparam logic [1:0] OP_ONESHOT  = 2'b01;
    localparam logic [1:0] OP_PERIODIC = 2'b10;
    localparam logic [1:0] OP_ABORT    = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StRun,
        StDone
    } state_e;

    function automatic logic is_start(input logic [1:0] op);
        return (op == OP_ONESHOT) || (op == OP_PERIODIC);
    endfunction

endpackage

// File: rtl/t_counter_ctrl_if.sv
// Command handshake and status bundle between a host and the T-counter sequencer.
interface t_counter_ctrl_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 8
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [WIDTH-1:0]      cmd_limit;
    logic [PRESCALE_W-1:0] cmd_prescale;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  done;
    logic                  cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_limit, cmd_prescale,
        input  cmd_ready, count, busy, done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_limit, cmd_prescale,
        output cmd_ready, count, busy, done, cmd_err
    );

endinterface

// File: rtl/t_counter_core.sv
// WIDTH-bit up-counter built from T flip-flops with synchronous clear.
module t_counter_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] t;

    // Bit i toggles only when enabled and every lower bit is set.
    assign t[0] = en_i;
    for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
        assign t[i] = en_i & (&q_q[i-1:0]);
    end

    assign q_d = clr_i ? '0 : (q_q ^ t);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/t_counter_ctrl.sv
// Command-driven sequencer: FSM, command latches and prescaler driving the T-counter core.
module t_counter_ctrl
    import t_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    t_counter_ctrl_if.slave bus_io
);

    state_e                state_q;
    logic [WIDTH-1:0]      limit_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] psc_q;
    logic                  periodic_q;
    logic                  done_q;
    logic                  cmd_err_q;

    logic [WIDTH-1:0] count;
    logic             ready;
    logic             accept;
    logic             stop_cmd;
    logic             abort_cmd;
    logic             tick;
    logic             at_limit;
    logic             cnt_clr;
    logic             cnt_en;

    assign ready     = (state_q != StArm);
    assign accept    = bus_io.cmd_valid & ready;
    assign stop_cmd  = accept & (bus_io.cmd_op == OP_STOP);
    assign abort_cmd = accept & (bus_io.cmd_op == OP_ABORT);
    assign tick      = (psc_q == prescale_q);
    assign at_limit  = (count == limit_q);

    // An accepted STOP/ABORT pre-empts a coincident terminal tick.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            StIdle, StDone: cnt_clr = abort_cmd;
            StArm:          cnt_clr = 1'b1;
            StRun: begin
                if (abort_cmd) begin
                    cnt_clr = 1'b1;
                end else if (!stop_cmd && tick) begin
                    if (!at_limit) begin
                        cnt_en = 1'b1;
                    end else begin
                        cnt_clr = periodic_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            limit_q    <= '0;
            prescale_q <= '0;
            psc_q      <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (accept && is_start(bus_io.cmd_op)) begin
                        limit_q    <= bus_io.cmd_limit;
                        prescale_q <= bus_io.cmd_prescale;
                        periodic_q <= (bus_io.cmd_op == OP_PERIODIC);
                        state_q    <= StArm;
                    end
                end
                StArm: begin
                    psc_q   <= '0;
                    state_q <= StRun;
                end
                StRun: begin
                    if (stop_cmd || abort_cmd) begin
                        state_q <= StIdle;
                    end else begin
                        psc_q <= tick ? '0 : psc_q + 1'b1;
                        // Only a start opcode can be left over here; it is rejected.
                        if (accept) begin
                            cmd_err_q <= 1'b1;
                        end
                        if (tick && at_limit) begin
                            done_q <= 1'b1;
                            if (!periodic_q) begin
                                state_q <= StDone;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    t_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .q_o   (count)
    );

    assign bus_io.cmd_ready = ready;
    assign bus_io.count     = count;
    assign bus_io.busy      = (state_q == StArm) || (state_q == StRun);
    assign bus_io.done      = done_q;
    assign bus_io.cmd_err   = cmd_err_q;

endmodule
